rd_bd_split: RTL and testbench
==============================

// Module: rd_bd_split
// PURPOSE
//  Read-descriptor splitter in the mmu_rx read path, directly upstream of the AXI4 read-master adapter's
//  72-bit command FIFO. Accepts one read buffer descriptor (addr, byte length, id) per handshake.
//  Breaks it into AXI-legal read commands: no command crosses a 2^SEG_LOG2-byte boundary.
//  Each command carries at most 2^SEG_LOG2 bytes. Writes the commands into the command FIFO,
//  marking the final segment of each descriptor with EOP.
// PARAMETERS
//  SEG_LOG2   12   log2 of max segment / boundary size in bytes; legal 6..12
//  CNT_W      32   width of statistic counters
// PORTS
//  aclk            in   1    clock
//  areset          in   1    asynchronous reset, active-high
//  bd_vld          in   1    descriptor valid
//  bd_rdy          out  1    descriptor ready; = (state==IDLE)
//  bd_addr         in   34   start byte address; must be 64B aligned
//  bd_len          in   16   length in bytes, 1..65535
//  bd_id           in   2    AXI id, copied to every command
//  rcmd_ff_full    in   1    command FIFO almost-full (>=400 of 512 entries)
//  rcmd_ff_wen     out  1    command write strobe (registered)
//  rcmd_ff_wdata   out  72   command (registered, format below)
//  bd_err          out  1    1-cycle pulse when a descriptor is dropped
//  reg_bd_cnt      out  CNT_W  descriptors accepted without error (wraps)
//  reg_cmd_cnt     out  CNT_W  commands written (wraps)
//  reg_err_cnt     out  CNT_W  descriptors dropped (saturates at all-ones)
// BEHAVIOUR
//  Command format:
//   - [33:0]=addr, [35:34]=id, [49:36]=segment bytes (1..4096).
//   - So [49:42] holds the 64B beat count, and [41:36] holds the byte remainder.
//   - [69]=EOP, [68]=ERR=0, all other bits 0.
//  Reset: state=IDLE; rcmd_ff_wen=0; rcmd_ff_wdata=0; bd_err=0; all counters=0; bd_rdy=1.
//  FSM IDLE:
//   - On bd_vld&bd_rdy, latch addr/len/id.
//   - If len==0 or addr[5:0]!=0: drop, pulse bd_err next cycle, reg_err_cnt+1, stay IDLE.
//   - Otherwise go to SPLIT.
//  FSM SPLIT, each cycle with rcmd_ff_full==0:
//   - seg = min(rem, 2^SEG_LOG2 - addr[SEG_LOG2-1:0]).
//   - Register wen=1 and wdata. Then addr+=seg, rem-=seg.
//   - If rem==seg: EOP=1, reg_bd_cnt+1, go to IDLE.
//  While rcmd_ff_full==1: no write, state held; no command is lost or duplicated.
//  Throughput and latency:
//   - One command per cycle.
//   - Descriptor accepted at edge N -> first wen high in the cycle after edge N+1.
//   - Next descriptor is accepted no earlier than the cycle after the EOP decision.
//  Width rules:
//   - rem is 17 bits and seg is 14 bits; the segment byte count is never 0.
//   - The address adder is 34 bits. Wrap past 2^34 is not checked; software must prevent it.
//  rcmd_ff_wen is deasserted in every cycle without a write (pulse per command).
//  areset mid-SPLIT discards the remaining segments; already-written commands stay in the FIFO.
//  Downstream flushes the FIFO on the same reset.
// CONFIGURATION
//  RD_BD_SPLIT_STAT_EN defined:
//   - reg_bd_cnt, reg_cmd_cnt and reg_err_cnt are implemented as described.
//  RD_BD_SPLIT_STAT_EN undefined:
//   - The three counters are tied to 0 and no counter flops are built.
//   - bd_err and all datapath behaviour are unchanged.
// TESTING
//  1 addr=0x0, len=256, id=1:
//    -> one cmd: addr 0, [49:42]=4, [41:36]=0, id=1, EOP=1; reg_cmd_cnt=1.
//  2 addr=0xF80, len=300:
//    -> cmd1: addr 0xF80, bytes 128 ([49:42]=2, rem 0), EOP=0.
//    -> cmd2: addr 0x1000, bytes 172 ([49:42]=2, [41:36]=44), EOP=1.
//  3 addr=0x0, len=65535:
//    -> 16 cmds on consecutive cycles, the first 15 at 4096 bytes ([49:42]=64).
//    -> last at addr 0xF000, [49:42]=63, [41:36]=63, EOP=1.
//  4 Case 3 with rcmd_ff_full forced high for 10 cycles after cmd 5:
//    -> no wen while full; cmds 6..16 resume with contiguous addresses.
//    -> exactly 16 cmds in total.
//  5 len=0, then addr=0x1001 len=64:
//    -> no wen; bd_err pulses twice; reg_err_cnt=2; bd_rdy stays 1.
//  6 areset asserted after cmd 3 of case 3:
//    -> wen=0 immediately, state IDLE, counters 0.
//    -> after release a new len=64 descriptor yields one EOP command.

Source files
------------

// File: rtl/rd_bd_split.sv
// Splits one read buffer descriptor into AXI read commands that never cross a 2^SEG_LOG2-byte boundary.
// Optional statistic counters are built only when RD_BD_SPLIT_STAT_EN is defined.
module rd_bd_split #(
    parameter int unsigned SEG_LOG2 = 12,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             bd_vld,
    output logic             bd_rdy,
    input  logic [33:0]      bd_addr,
    input  logic [15:0]      bd_len,
    input  logic [1:0]       bd_id,
    input  logic             rcmd_ff_full,
    output logic             rcmd_ff_wen,
    output logic [71:0]      rcmd_ff_wdata,
    output logic             bd_err,
    output logic [CNT_W-1:0] reg_bd_cnt,
    output logic [CNT_W-1:0] reg_cmd_cnt,
    output logic [CNT_W-1:0] reg_err_cnt
);

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    state_t state_q, state_d;

    logic [33:0]         addr_q, addr_d;
    logic [16:0]         rem_q, rem_d;
    logic [1:0]          id_q, id_d;
    logic                wen_d;
    logic [71:0]         wdata_d;
    logic                err_d;
    logic [SEG_LOG2:0]   room;
    logic [13:0]         seg;
    logic                last_seg;
    logic                desc_bad;

    assign bd_rdy   = (state_q == IDLE);
    assign desc_bad = (bd_len == 16'd0) || (bd_addr[5:0] != 6'd0);

    // Bytes left before the next boundary; the final segment is whatever remains when it fits.
    assign room     = {1'b1, {SEG_LOG2{1'b0}}} - {1'b0, addr_q[SEG_LOG2-1:0]};
    assign last_seg = (rem_q <= 17'(room));
    assign seg      = last_seg ? 14'(rem_q) : 14'(room);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bd_vld && !desc_bad) state_d = SPLIT;
            SPLIT:   if (!rcmd_ff_full && last_seg) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d  = addr_q;
        rem_d   = rem_q;
        id_d    = id_q;
        wen_d   = 1'b0;
        wdata_d = '0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bd_vld) begin
                    if (desc_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d = bd_addr;
                        rem_d  = {1'b0, bd_len};
                        id_d   = bd_id;
                    end
                end
            end
            SPLIT: begin
                if (!rcmd_ff_full) begin
                    wen_d          = 1'b1;
                    wdata_d[33:0]  = addr_q;
                    wdata_d[35:34] = id_q;
                    wdata_d[49:36] = seg;
                    wdata_d[69]    = last_seg;
                    addr_d         = addr_q + 34'(seg);
                    rem_d          = rem_q - 17'(seg);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_q        <= '0;
            rem_q         <= '0;
            id_q          <= '0;
            rcmd_ff_wen   <= 1'b0;
            rcmd_ff_wdata <= '0;
            bd_err        <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            rem_q         <= rem_d;
            id_q          <= id_d;
            rcmd_ff_wen   <= wen_d;
            rcmd_ff_wdata <= wdata_d;
            bd_err        <= err_d;
        end
    end

`ifdef RD_BD_SPLIT_STAT_EN
    logic [CNT_W-1:0] bd_cnt_q, cmd_cnt_q, err_cnt_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bd_cnt_q  <= '0;
            cmd_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (wen_d) cmd_cnt_q <= cmd_cnt_q + CNT_W'(1);
            if (wen_d && last_seg) bd_cnt_q <= bd_cnt_q + CNT_W'(1);
            if (err_d && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign reg_bd_cnt  = bd_cnt_q;
    assign reg_cmd_cnt = cmd_cnt_q;
    assign reg_err_cnt = err_cnt_q;
`else
    assign reg_bd_cnt  = '0;
    assign reg_cmd_cnt = '0;
    assign reg_err_cnt = '0;
`endif

endmodule

// File: tb/tb_rd_bd_split.sv
// Directed-vector bench for rd_bd_split; counter expectations follow RD_BD_SPLIT_STAT_EN.
module tb_rd_bd_split;

    logic        aclk = 1'b0;
    logic        areset;
    logic        bd_vld;
    logic        bd_rdy;
    logic [33:0] bd_addr;
    logic [15:0] bd_len;
    logic [1:0]  bd_id;
    logic        rcmd_ff_full;
    logic        rcmd_ff_wen;
    logic [71:0] rcmd_ff_wdata;
    logic        bd_err;
    logic [31:0] reg_bd_cnt;
    logic [31:0] reg_cmd_cnt;
    logic [31:0] reg_err_cnt;

    rd_bd_split #(.SEG_LOG2(12), .CNT_W(32)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .bd_vld        (bd_vld),
        .bd_rdy        (bd_rdy),
        .bd_addr       (bd_addr),
        .bd_len        (bd_len),
        .bd_id         (bd_id),
        .rcmd_ff_full  (rcmd_ff_full),
        .rcmd_ff_wen   (rcmd_ff_wen),
        .rcmd_ff_wdata (rcmd_ff_wdata),
        .bd_err        (bd_err),
        .reg_bd_cnt    (reg_bd_cnt),
        .reg_cmd_cnt   (reg_cmd_cnt),
        .reg_err_cnt   (reg_err_cnt)
    );

    always #5 aclk = ~aclk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [71:0] cmd_q[$];
    int unsigned cmd_cyc[$];
    int unsigned cyc = 0;
    int unsigned err_pulses = 0;
    int unsigned full_viol = 0;
    int unsigned rdy_drops = 0;
    logic        full_at_edge = 1'b0;

    always @(posedge aclk) begin
        cyc          <= cyc + 1;
        full_at_edge <= rcmd_ff_full;
    end

    always @(negedge aclk) begin
        if (rcmd_ff_wen === 1'b1) begin
            cmd_q.push_back(rcmd_ff_wdata);
            cmd_cyc.push_back(cyc);
            if (full_at_edge) full_viol++;
        end
        if (bd_err === 1'b1) err_pulses++;
        if (bd_rdy !== 1'b1 && !areset) rdy_drops++;
    end

    task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [71:0] mk(input logic [33:0] a, input logic [1:0] id,
                                       input logic [13:0] bytes, input logic eop);
        mk         = '0;
        mk[33:0]   = a;
        mk[35:34]  = id;
        mk[49:36]  = bytes;
        mk[69]     = eop;
    endfunction

    function automatic logic [71:0] st(input int unsigned v);
`ifdef RD_BD_SPLIT_STAT_EN
        st = 72'(v);
`else
        st = '0;
`endif
    endfunction

    // Called just after a rising edge while bd_rdy is high; the next edge accepts.
    task automatic send(input logic [33:0] a, input logic [15:0] l, input logic [1:0] id);
        bd_addr = a;
        bd_len  = l;
        bd_id   = id;
        bd_vld  = 1'b1;
        @(posedge aclk);
        #1 bd_vld = 1'b0;
    endtask

    task automatic wait_eop(input string tag);
        int unsigned n = 0;
        while ((cmd_q.size() == 0 || cmd_q[cmd_q.size()-1][69] !== 1'b1) && n < 300) begin
            @(negedge aclk);
            n++;
        end
        if (n >= 300) check({tag, "_timeout"}, 72'd0, 72'd1);
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic wait_n(input int unsigned cnt, input string tag);
        int unsigned n = 0;
        while (cmd_q.size() < cnt && n < 300) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (n >= 300) check({tag, "_timeout"}, 72'd0, 72'd1);
    endtask

    task automatic check_big(input string tag);
        logic [71:0] act;
        check({tag, "_count"}, 72'(cmd_q.size()), 72'd16);
        for (int i = 0; i < 16; i++) begin
            act = (i < cmd_q.size()) ? cmd_q[i] : '0;
            if (i < 15) check($sformatf("%s_cmd%0d", tag, i), act, mk(34'(i * 4096), 2'd2, 14'd4096, 1'b0));
            else        check($sformatf("%s_cmd%0d", tag, i), act, mk(34'hF000, 2'd2, 14'd4095, 1'b1));
        end
    endtask

    initial begin
        int unsigned acc_cyc;
        logic [71:0] c;

        areset       = 1'b1;
        bd_vld       = 1'b0;
        bd_addr      = '0;
        bd_len       = '0;
        bd_id        = '0;
        rcmd_ff_full = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_wen",   72'(rcmd_ff_wen),   72'd0);
        check("rst_wdata", rcmd_ff_wdata,      72'd0);
        check("rst_err",   72'(bd_err),        72'd0);
        check("rst_rdy",   72'(bd_rdy),        72'd1);
        check("rst_cmdc",  72'(reg_cmd_cnt),   72'd0);
        @(negedge aclk) areset = 1'b0;
        @(posedge aclk);
        #1;

        // 1: single 256-byte command
        cmd_q.delete(); cmd_cyc.delete();
        send(34'h0, 16'd256, 2'd1);
        acc_cyc = cyc;
        wait_eop("t1");
        check("t1_count", 72'(cmd_q.size()), 72'd1);
        c = cmd_q[0];
        check("t1_cmd",   c, mk(34'h0, 2'd1, 14'd256, 1'b1));
        check("t1_beats", 72'(c[49:42]), 72'd4);
        check("t1_lat",   72'(cmd_cyc[0]), 72'(acc_cyc + 1));
        check("t1_cmdc",  72'(reg_cmd_cnt), st(1));
        check("t1_bdc",   72'(reg_bd_cnt),  st(1));

        // 2: boundary split at 0x1000
        cmd_q.delete(); cmd_cyc.delete();
        send(34'hF80, 16'd300, 2'd0);
        wait_eop("t2");
        check("t2_count", 72'(cmd_q.size()), 72'd2);
        check("t2_cmd0",  cmd_q[0], mk(34'hF80,  2'd0, 14'd128, 1'b0));
        c = cmd_q[1];
        check("t2_cmd1",  c, mk(34'h1000, 2'd0, 14'd172, 1'b1));
        check("t2_rmd",   72'(c[41:36]), 72'd44);

        // 3: maximum length, back-to-back commands
        cmd_q.delete(); cmd_cyc.delete();
        send(34'h0, 16'd65535, 2'd2);
        wait_eop("t3");
        check_big("t3");
        check("t3_consec", 72'(cmd_cyc[15] - cmd_cyc[0]), 72'd15);
        check("t3_cmdc",   72'(reg_cmd_cnt), st(19));
        check("t3_bdc",    72'(reg_bd_cnt),  st(3));

        // 4: FIFO full for 10 cycles after the fifth command
        cmd_q.delete(); cmd_cyc.delete(); full_viol = 0;
        send(34'h0, 16'd65535, 2'd2);
        wait_n(5, "t4_five");
        rcmd_ff_full = 1'b1;
        repeat (10) @(negedge aclk);
        rcmd_ff_full = 1'b0;
        wait_eop("t4");
        check_big("t4");
        check("t4_noviol", 72'(full_viol), 72'd0);
        check("t4_gap",    72'(cmd_cyc[5] - cmd_cyc[4]), 72'd11);
        check("t4_cmdc",   72'(reg_cmd_cnt), st(35));

        // 5: two dropped descriptors
        cmd_q.delete(); cmd_cyc.delete(); err_pulses = 0; rdy_drops = 0;
        send(34'h0,    16'd0,  2'd0);
        send(34'h1001, 16'd64, 2'd0);
        repeat (3) @(posedge aclk);
        #1;
        check("t5_nocmd", 72'(cmd_q.size()), 72'd0);
        check("t5_errp",  72'(err_pulses),   72'd2);
        check("t5_rdy",   72'(rdy_drops),    72'd0);
        check("t5_errc",  72'(reg_err_cnt),  st(2));

        // 6: reset in the middle of a split
        cmd_q.delete(); cmd_cyc.delete();
        send(34'h0, 16'd65535, 2'd2);
        wait_n(3, "t6_three");
        areset = 1'b1;
        #1;
        check("t6_wen",   72'(rcmd_ff_wen), 72'd0);
        check("t6_rdy",   72'(bd_rdy),      72'd1);
        check("t6_cmdc",  72'(reg_cmd_cnt), 72'd0);
        check("t6_errc",  72'(reg_err_cnt), 72'd0);
        repeat (3) @(posedge aclk);
        @(negedge aclk) areset = 1'b0;
        @(posedge aclk);
        #1;
        check("t6_held",  72'(cmd_q.size()), 72'd3);
        send(34'h2000, 16'd64, 2'd3);
        wait_eop("t6");
        check("t6_count", 72'(cmd_q.size()), 72'd4);
        check("t6_cmd",   cmd_q[3], mk(34'h2000, 2'd3, 14'd64, 1'b1));
        check("t6_cmdc2", 72'(reg_cmd_cnt), st(1));
        check("t6_bdc",   72'(reg_bd_cnt),  st(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
